dmem: RTL and testbench

//   Word-organised data memory for the MIPS single-cycle datapath, driven by
//   the MEM stage.
//   - Synchronous write on the rising clock edge.
//   - Combinational read, gated by readmode.
//   - Asynchronous clear of all contents on reset.

---
 rtl/mips_pkg.sv | 9 +
 rtl/dmem.sv | 41 ++++
 tb/tb_dmem.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Constants and types shared by the MIPS datapath memories and register file.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/dmem.sv
// Word-organised data memory for the MEM stage: synchronous write, gated combinational
// read, asynchronous clear of every word on reset.
module dmem
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned DEPTH  = mips_pkg::DEPTH
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [DATA_W-1:0] out,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              readmode,
  input  logic              writemode
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  // Byte offset and upper address bits are dropped, so addresses wrap modulo DEPTH*4.
  assign idx = address[IDX_W+1:2];

  logic unused_addr;
  assign unused_addr = ^{address[31:IDX_W+2], address[1:0]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (writemode) begin
      mem[idx] <= dataIn;
    end
  end

  assign out = (readmode && !Reset) ? mem[idx] : '0;

endmodule

// File: tb/tb_dmem.sv
// Randomised self-checking bench for dmem against an array-based reference memory.
module tb_dmem;

  localparam int unsigned DEPTH = 64;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] out;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic        readmode;
  logic        writemode;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];

  dmem dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .out       (out),
    .address   (address),
    .dataIn    (dataIn),
    .readmode  (readmode),
    .writemode (writemode)
  );

  always #5 Clk = ~Clk;

  // Reference model: word index is the byte address divided by four, modulo the depth.
  always @(posedge Reset) begin
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
  end

  always @(posedge Clk) begin
    if (!Reset && writemode === 1'b1) ref_mem[(address / 4) % DEPTH] = dataIn;
  end

  function automatic logic [31:0] model_out(input logic [31:0] a, input logic rm,
                                            input logic rst);
    if (rst || !rm) return '0;
    return ref_mem[(a / 4) % DEPTH];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge Clk);
    address   = a;
    dataIn    = d;
    writemode = 1'b1;
    readmode  = 1'b0;
    @(negedge Clk);
    writemode = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    Reset     = 1'b1;
    address   = '0;
    dataIn    = '0;
    readmode  = 1'b0;
    writemode = 1'b0;
    #12;
    Reset = 1'b0;
    readmode = 1'b1;
    #1 check("reset_state", out, 32'h0);

    // Reset clear, mid-cycle, no clock edge needed.
    write_word(32'h3, 32'h55);
    address  = 32'h3;
    readmode = 1'b1;
    #1 check("pre_reset_value", out, 32'h55);
    Reset = 1'b1;
    #1 check("reset_async_out", out, 32'h0);
    #1 Reset = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      address = 32'(i * 4);
      #1 check("reset_clear_all", out, 32'h0);
    end

    // Write then read, low address bits ignored.
    write_word(32'h3, 32'h111);
    address  = 32'h3;
    readmode = 1'b1;
    #1 check("write_read_idx0", out, 32'h0000_0111);

    // Alias / wrap at DEPTH*4 bytes.
    write_word(32'h104, 32'hDEAD_BEEF);
    readmode = 1'b1;
    address  = 32'h004;
    #1 check("wrap_read_004", out, 32'hDEAD_BEEF);
    address  = 32'h007;
    #1 check("wrap_read_007", out, 32'hDEAD_BEEF);

    // Read gating.
    readmode = 1'b0;
    #1 check("gate_off", out, 32'h0);
    readmode = 1'b1;
    #0 #0 check("gate_on_same_step", out, 32'hDEAD_BEEF);

    // Same-index write and read across an edge.
    write_word(32'h8, 32'hA5A5_A5A5);
    address   = 32'h8;
    dataIn    = 32'h1234_5678;
    readmode  = 1'b1;
    writemode = 1'b1;
    #1 check("rw_before_edge", out, 32'hA5A5_A5A5);
    @(posedge Clk);
    #1 check("rw_after_edge", out, 32'h1234_5678);
    @(negedge Clk);
    writemode = 1'b0;

    // Reset held across a write edge blocks the write.
    Reset     = 1'b1;
    address   = 32'h10;
    dataIn    = 32'h0000_00FF;
    writemode = 1'b1;
    @(posedge Clk);
    #1 check("reset_during_write_out", out, 32'h0);
    @(negedge Clk);
    writemode = 1'b0;
    Reset     = 1'b0;
    readmode  = 1'b1;
    #1 check("reset_during_write_mem", out, 32'h0);
    address = 32'h8;
    #1 check("reset_cleared_idx2", out, 32'h0);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      @(negedge Clk);
      address   = {$urandom_range(3, 0) == 0 ? $urandom() : {24'h0, 8'($urandom())}};
      dataIn    = $urandom();
      readmode  = 1'($urandom());
      writemode = 1'($urandom());
      #1 check("rand_pre_edge", out, model_out(address, readmode, Reset));
      if ($urandom_range(49, 0) == 0) begin
        Reset = 1'b1;
        #1 check("rand_reset", out, 32'h0);
        Reset = 1'b0;
        #1 check("rand_post_reset", out, model_out(address, readmode, Reset));
      end
      @(posedge Clk);
      #1 check("rand_post_edge", out, model_out(address, readmode, Reset));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
